output_fifo_holder: RTL and testbench

- Parametrised successor to the single-byte output holder.
- Buffers up to DEPTH pulsed results from the encryption block and presents the oldest one on data_out until the chip user acknowledges the read.
- Sits between the cipher core and the output mux, and reports empty/ready status to the interface FSM.
- Adds queueing, read acknowledge, a configurable full-buffer policy, a sticky overflow flag and an explicit flush.

---
 rtl/output_fifo_holder_if.sv | 38 +++
 rtl/output_fifo_holder.sv | 90 +++++++++
 tb/tb_output_fifo_holder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/output_fifo_holder_if.sv
// Status type and handshake bundle between the cipher core, the output holder
// and the interface FSM. Clock and reset stay outside the bundle.
package output_fifo_holder_pkg;
    typedef enum logic {
        O_EMPTY = 1'b0,
        O_READY = 1'b1
    } output_holder_state_t;
endpackage

interface output_fifo_holder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    import output_fifo_holder_pkg::*;

    // Strobes are single-cycle and sampled on the rising edge; there is no
    // back-pressure: a push into a full holder is resolved by the holder's
    // full-buffer policy, and a read_ack while empty is ignored.
    logic [DATA_WIDTH-1:0]        data_in;
    logic                         data_in_pulse;
    logic                         read_ack;
    logic                         flush;
    logic [DATA_WIDTH-1:0]        data_out;
    output_holder_state_t         output_holder_state_out;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         full;
    logic                         overflow;

    modport master (
        output data_in, data_in_pulse, read_ack, flush,
        input  data_out, output_holder_state_out, count, full, overflow
    );

    modport slave (
        input  data_in, data_in_pulse, read_ack, flush,
        output data_out, output_holder_state_out, count, full, overflow
    );
endinterface

// File: rtl/output_fifo_holder.sv
// Circular buffer of DEPTH cipher results; the oldest word is shown on
// data_out until the interface FSM acknowledges it.
module output_fifo_holder
    import output_fifo_holder_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int DROP_OLDEST = 0
) (
    input  logic                 clk,
    input  logic                 nrst,
    output_fifo_holder_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  pop;
    logic                  is_full;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        is_full    = (count_q == CNT_FULL);
        pop        = bus.read_ack && (count_q != '0);

        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (bus.data_in_pulse && pop) begin
            mem_d[wr_ptr_q] = bus.data_in;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end else if (bus.data_in_pulse && !is_full) begin
            mem_d[wr_ptr_q] = bus.data_in;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            count_d         = count_q + CNT_W'(1);
        end else if (bus.data_in_pulse) begin
            overflow_d = 1'b1;
            // Overwrite policy: the slot after the head becomes the new head.
            if (DROP_OLDEST != 0) begin
                mem_d[wr_ptr_q] = bus.data_in;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
                rd_ptr_d        = ptr_inc(rd_ptr_q);
            end
        end else if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d  = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.data_out                = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.output_holder_state_out = (count_q != '0) ? O_READY : O_EMPTY;
    assign bus.count                   = count_q;
    assign bus.full                    = is_full;
    assign bus.overflow                = overflow_q;
endmodule

// File: tb/tb_output_fifo_holder.sv
// Bench for output_fifo_holder: one instance per full-buffer policy, both fed
// the same directed stimulus and compared every cycle against a queue model.
module tb_output_fifo_holder;
    import output_fifo_holder_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          nrst;
    logic          pulse;
    logic          ack;
    logic          fl;
    logic [DW-1:0] din;

    int checks = 0;
    int errors = 0;

    output_fifo_holder_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
    output_fifo_holder_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

    assign bus0.data_in       = din;
    assign bus0.data_in_pulse = pulse;
    assign bus0.read_ack      = ack;
    assign bus0.flush         = fl;
    assign bus1.data_in       = din;
    assign bus1.data_in_pulse = pulse;
    assign bus1.read_ack      = ack;
    assign bus1.flush         = fl;

    output_fifo_holder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_OLDEST(0)) dut0 (
        .clk(clk), .nrst(nrst), .bus(bus0)
    );
    output_fifo_holder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_OLDEST(1)) dut1 (
        .clk(clk), .nrst(nrst), .bus(bus1)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of buffered words plus a sticky overflow bit.
    for (genvar g = 0; g < 2; g++) begin : mdl
        logic [DW-1:0] q[$];
        logic          ovf;
        always @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                q.delete();
                ovf <= 1'b0;
            end else if (fl) begin
                q.delete();
                ovf <= 1'b0;
            end else if (pulse && ack && q.size() != 0) begin
                void'(q.pop_front());
                q.push_back(din);
            end else if (pulse) begin
                if (q.size() < DEPTH) begin
                    q.push_back(din);
                end else begin
                    ovf <= 1'b1;
                    if (g == 1) begin
                        void'(q.pop_front());
                        q.push_back(din);
                    end
                end
            end else if (ack && q.size() != 0) begin
                void'(q.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_one(input string tag, input int sz, input logic [DW-1:0] head,
                           input logic m_ovf, input logic [DW-1:0] dout, input int cnt,
                           input logic f, input logic st, input logic ovf);
        check({tag, ".data_out"}, 32'(dout), (sz > 0) ? 32'(head) : 32'h0);
        check({tag, ".count"}, 32'(cnt), 32'(sz));
        check({tag, ".full"}, 32'(f), 32'(sz == DEPTH));
        check({tag, ".state"}, 32'(st), (sz > 0) ? 32'(O_READY) : 32'(O_EMPTY));
        check({tag, ".overflow"}, 32'(ovf), 32'(m_ovf));
    endtask

    // Scoreboard compare on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            cmp_one("m0", mdl[0].q.size(), (mdl[0].q.size() > 0) ? mdl[0].q[0] : '0, mdl[0].ovf,
                    bus0.data_out, int'(bus0.count), bus0.full,
                    bus0.output_holder_state_out, bus0.overflow);
            cmp_one("m1", mdl[1].q.size(), (mdl[1].q.size() > 0) ? mdl[1].q[0] : '0, mdl[1].ovf,
                    bus1.data_out, int'(bus1.count), bus1.full,
                    bus1.output_holder_state_out, bus1.overflow);
        end
    end

    // Driver: one clock cycle with the given strobes, then back to idle.
    task automatic step(input logic p, input logic [DW-1:0] d, input logic a, input logic f);
        pulse = p;
        din   = d;
        ack   = a;
        fl    = f;
        @(posedge clk);
        #1;
        pulse = 1'b0;
        ack   = 1'b0;
        fl    = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_flush();
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        pulse = 1'b0;
        ack   = 1'b0;
        fl    = 1'b0;
        din   = '0;
        nrst  = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;

        // Reset state after three idle cycles
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        check("rst.data_out", 32'(bus0.data_out), 32'h0);
        check("rst.count", 32'(bus0.count), 32'd0);
        check("rst.state", 32'(bus0.output_holder_state_out), 32'(O_EMPTY));
        check("rst.full", 32'(bus0.full), 32'd0);
        check("rst.overflow", 32'(bus0.overflow), 32'd0);

        // Basic push / ack
        push(8'h11); push(8'h22); push(8'h33);
        check("basic.count3", 32'(bus0.count), 32'd3);
        check("basic.head11", 32'(bus0.data_out), 32'h11);
        pop_one();
        check("basic.head22", 32'(bus0.data_out), 32'h22);
        check("basic.count2", 32'(bus0.count), 32'd2);
        do_flush();

        // Full buffer, both policies
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        check("drop.full", 32'(bus0.full), 32'd1);
        push(8'hA4);
        check("drop.count", 32'(bus0.count), 32'd4);
        check("drop.head", 32'(bus0.data_out), 32'hA0);
        check("drop.overflow", 32'(bus0.overflow), 32'd1);
        check("ovw.head", 32'(bus1.data_out), 32'hA1);
        check("ovw.count", 32'(bus1.count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drop.drain%0d", i), 32'(bus0.data_out), 32'hA0 + 32'(i));
            pop_one();
        end
        check("drop.empty", 32'(bus0.output_holder_state_out), 32'(O_EMPTY));
        check("drop.sticky", 32'(bus0.overflow), 32'd1);
        do_flush();

        for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
        check("ovw.countB", 32'(bus1.count), 32'd4);
        check("ovw.headB1", 32'(bus1.data_out), 32'hB1);
        check("ovw.overflow", 32'(bus1.overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovw.drain%0d", i), 32'(bus1.data_out), 32'hB1 + 32'(i));
            pop_one();
        end
        check("ovw.empty", 32'(bus1.output_holder_state_out), 32'(O_EMPTY));
        do_flush();

        // Pointer wrap with interleaved push+pop: nine pushes wrap twice
        push(8'hC0); push(8'hC1); push(8'hC2);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("wrap.head%0d", i), 32'(bus0.data_out), 32'hC0 + 32'(i));
            step(1'b1, 8'hC3 + 8'(i), 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wrap.tail%0d", i), 32'(bus0.data_out), 32'hC6 + 32'(i));
            pop_one();
        end
        check("wrap.count0", 32'(bus0.count), 32'd0);
        do_flush();

        // Simultaneous push+pop while full is not an overflow
        for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
        step(1'b1, 8'hD4, 1'b1, 1'b0);
        check("fullpp.count", 32'(bus0.count), 32'd4);
        check("fullpp.overflow", 32'(bus0.overflow), 32'd0);
        check("fullpp.head", 32'(bus0.data_out), 32'hD1);
        check("fullpp.ovw_overflow", 32'(bus1.overflow), 32'd0);
        do_flush();

        // Simultaneous push+pop while empty, then pop on empty
        step(1'b1, 8'hE0, 1'b1, 1'b0);
        check("emptypp.count", 32'(bus0.count), 32'd1);
        check("emptypp.head", 32'(bus0.data_out), 32'hE0);
        pop_one();
        pop_one();
        check("underflow.count", 32'(bus0.count), 32'd0);
        check("underflow.data_out", 32'(bus0.data_out), 32'h0);
        do_flush();

        // Flush beats a same-cycle push
        for (int i = 0; i < 5; i++) push(8'hF0 + 8'(i));
        pop_one();
        check("flush.pre_count", 32'(bus0.count), 32'd3);
        check("flush.pre_ovf", 32'(bus0.overflow), 32'd1);
        check("flush.pre_head", 32'(bus0.data_out), 32'hF1);
        step(1'b1, 8'h55, 1'b0, 1'b1);
        check("flush.count", 32'(bus0.count), 32'd0);
        check("flush.overflow", 32'(bus0.overflow), 32'd0);
        check("flush.data_out", 32'(bus0.data_out), 32'h0);
        check("flush.state", 32'(bus0.output_holder_state_out), 32'(O_EMPTY));

        // Asynchronous reset mid-operation
        push(8'h66); push(8'h77);
        check("areset.pre_count", 32'(bus0.count), 32'd2);
        #1 nrst = 1'b0;
        #1;
        check("areset.count", 32'(bus0.count), 32'd0);
        check("areset.data_out", 32'(bus0.data_out), 32'h0);
        check("areset.state", 32'(bus0.output_holder_state_out), 32'(O_EMPTY));
        check("areset.ovw_count", 32'(bus1.count), 32'd0);
        @(posedge clk);
        #1 nrst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        check("areset.after", 32'(bus0.count), 32'd0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
